// File: rtl/hp_fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hp_fpu_pkg
// Desc    : Shared encodings and types for the half-precision FPU controller.
// Revision: 1.0 - initial release
// ============================================================================
package hp_fpu_pkg;

    // {op[2:1] = ADD/SUB/MUL/DIV, op[0] = stochastic rounding}
    localparam logic [2:0] c_ADD_RN = 3'b000;
    localparam logic [2:0] c_ADD_SR = 3'b001;
    localparam logic [2:0] c_SUB_RN = 3'b010;
    localparam logic [2:0] c_SUB_SR = 3'b011;
    localparam logic [2:0] c_MUL_RN = 3'b100;
    localparam logic [2:0] c_MUL_SR = 3'b101;
    localparam logic [2:0] c_DIV_RN = 3'b110;
    localparam logic [2:0] c_DIV_SR = 3'b111;

    localparam int c_FLAG_ZERO = 5;
    localparam int c_FLAG_INF  = 4;
    localparam int c_FLAG_SUBN = 3;
    localparam int c_FLAG_NORM = 2;
    localparam int c_FLAG_QNAN = 1;
    localparam int c_FLAG_SNAN = 0;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_EXEC = 1'b1;

    // Default-configuration response entry (16-bit result, 3-bit tag)
    typedef struct packed {
        logic [15:0] result;
        logic [5:0]  flags;
        logic [2:0]  tag;
    } resp_t;

endpackage
`default_nettype wire

// File: rtl/hp_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : hp_resp_fifo
// Desc    : Small circular response queue with push/pop/count/full/empty.
// Revision: 1.0 - initial release
// ============================================================================
module hp_resp_fifo
    import hp_fpu_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = resp_t,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    output T              head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int            PW     = $clog2(DEPTH);
    localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == c_FULL);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_q];
    assign w_do_pop  = pop_i && !empty_o;
    // A push into a full queue is only legal when the head leaves the same cycle
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= (wr_q == c_LAST) ? '0 : wr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_q <= (rd_q == c_LAST) ? '0 : rd_q + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hp_fpu_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hp_fpu_req_ctrl
// Desc    : Core-side request/response controller for the half-precision FPU.
//           Optional sticky flag accumulation enabled by HP_STICKY_FLAGS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module hp_fpu_req_ctrl
    import hp_fpu_pkg::*;
#(
    parameter int num_bits    = 16,
    parameter int tag_width   = 3,
    parameter int resp_depth  = 2,
    parameter int fpu_latency = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [num_bits-1:0]  req_src_a,
    input  logic [num_bits-1:0]  req_src_b,
    input  logic [2:0]           req_op,
    input  logic [tag_width-1:0] req_tag,
    output logic [num_bits-1:0]  fpu_src_a,
    output logic [num_bits-1:0]  fpu_src_b,
    output logic [2:0]           fpu_operation,
    input  logic [num_bits-1:0]  fpu_res,
    input  logic [5:0]           fpu_flags,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [num_bits-1:0]  resp_result,
    output logic [5:0]           resp_flags,
    output logic [tag_width-1:0] resp_tag,
    output logic                 busy
`ifdef HP_STICKY_FLAGS_EN
    ,
    input  logic                 flag_clear,
    output logic [5:0]           sticky_flags
`endif
);
    localparam int            CW           = $clog2(resp_depth + 1);
    localparam logic [CW-1:0] c_DEPTH_M1   = CW'(resp_depth - 1);
    localparam logic [1:0]    c_CNT_RELOAD = 2'(fpu_latency - 1);

    typedef struct packed {
        logic [num_bits-1:0]  result;
        logic [5:0]           flags;
        logic [tag_width-1:0] tag;
    } entry_t;

    logic [0:0]           state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [num_bits-1:0]  src_a_q, src_a_d;
    logic [num_bits-1:0]  src_b_q, src_b_d;
    logic [2:0]           op_q, op_d;
    logic [tag_width-1:0] tag_q, tag_d;

    logic          w_done;
    logic          w_pop;
    logic          w_accept;
    logic          w_space;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    entry_t        w_push_data;
    entry_t        w_head;

    assign w_done      = (state_q == c_ST_EXEC) && (cnt_q == 2'd0);
    assign w_pop       = resp_valid && resp_ready;
    assign w_accept    = req_valid && req_ready;
    assign w_push_data = '{result: fpu_res, flags: fpu_flags, tag: tag_q};

    // In the completing cycle the slot being freed by a pop can be reused
    always_comb begin
        w_space = 1'b0;
        if (state_q == c_ST_IDLE) begin
            w_space = !w_full;
        end else if (w_done) begin
            w_space = w_pop ? !w_full : (w_count < c_DEPTH_M1);
        end
    end

    assign req_ready = w_space && !reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        op_d    = op_q;
        tag_d   = tag_q;
        if (w_accept) begin
            state_d = c_ST_EXEC;
            cnt_d   = c_CNT_RELOAD;
            src_a_d = req_src_a;
            src_b_d = req_src_b;
            op_d    = req_op;
            tag_d   = req_tag;
        end else if (state_q == c_ST_EXEC) begin
            if (w_done) begin
                state_d = c_ST_IDLE;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            op_q    <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
        end
    end

    hp_resp_fifo #(
        .DEPTH (resp_depth),
        .T     (entry_t)
    ) u_resp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_done),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign fpu_src_a     = src_a_q;
    assign fpu_src_b     = src_b_q;
    assign fpu_operation = op_q;
    assign resp_valid    = !w_empty;
    assign resp_result   = w_head.result;
    assign resp_flags    = w_head.flags;
    assign resp_tag      = w_head.tag;
    assign busy          = (state_q == c_ST_EXEC) || !w_empty;

`ifdef HP_STICKY_FLAGS_EN
    logic [5:0] sticky_q;

    // A clear coinciding with a push keeps only the new flags
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
        end else if (flag_clear) begin
            sticky_q <= w_done ? fpu_flags : 6'b0;
        end else if (w_done) begin
            sticky_q <= sticky_q | fpu_flags;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hp_fpu_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hp_fpu_req_ctrl
// Desc    : Self-checking bench: latency-1 and latency-3 controller instances
//           driven against a stub FPU and a queue-based response model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hp_fpu_req_ctrl;
    import hp_fpu_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic [5:0]  fl;
        logic [2:0]  tag;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: fpu_latency = 1
    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_busy;
    logic [15:0] a_req_src_a, a_req_src_b, a_fpu_src_a, a_fpu_src_b, a_fpu_res, a_resp_result;
    logic [2:0]  a_req_op, a_req_tag, a_fpu_op, a_resp_tag;
    logic [5:0]  a_fpu_flags, a_resp_flags;
    // Instance B: fpu_latency = 3
    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_busy;
    logic [15:0] b_req_src_a, b_req_src_b, b_fpu_src_a, b_fpu_src_b, b_fpu_res, b_resp_result;
    logic [2:0]  b_req_op, b_req_tag, b_fpu_op, b_resp_tag;
    logic [5:0]  b_fpu_flags, b_resp_flags;
`ifdef HP_STICKY_FLAGS_EN
    logic        a_flag_clear, b_flag_clear;
    logic [5:0]  a_sticky, b_sticky;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    rsp_t a_exp[$], a_obs[$], b_exp[$], b_obs[$];

    // Stub FPU: two exact half-precision cases, otherwise an arbitrary mix
    function automatic logic [15:0] fpu_res_f(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op);
        if (op == c_ADD_RN && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        if (op == c_MUL_RN && a == 16'h7BFF && b == 16'h4000) return 16'h7C00;
        return (a ^ {b[7:0], b[15:8]}) + {13'd0, op};
    endfunction

    function automatic logic [5:0] fpu_flags_f(input logic [15:0] a, input logic [15:0] b,
                                               input logic [2:0] op);
        if (op == c_ADD_RN && a == 16'h3C00 && b == 16'h4000) return 6'b000100;
        if (op == c_MUL_RN && a == 16'h7BFF && b == 16'h4000) return 6'b010000;
        return {a[2:0] ^ op, b[2:0]};
    endfunction

    assign a_fpu_res   = fpu_res_f(a_fpu_src_a, a_fpu_src_b, a_fpu_op);
    assign a_fpu_flags = fpu_flags_f(a_fpu_src_a, a_fpu_src_b, a_fpu_op);
    assign b_fpu_res   = fpu_res_f(b_fpu_src_a, b_fpu_src_b, b_fpu_op);
    assign b_fpu_flags = fpu_flags_f(b_fpu_src_a, b_fpu_src_b, b_fpu_op);

    hp_fpu_req_ctrl #(.num_bits(16), .tag_width(3), .resp_depth(2), .fpu_latency(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_src_a(a_req_src_a), .req_src_b(a_req_src_b), .req_op(a_req_op), .req_tag(a_req_tag),
        .fpu_src_a(a_fpu_src_a), .fpu_src_b(a_fpu_src_b), .fpu_operation(a_fpu_op),
        .fpu_res(a_fpu_res), .fpu_flags(a_fpu_flags),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_result(a_resp_result), .resp_flags(a_resp_flags), .resp_tag(a_resp_tag),
        .busy(a_busy)
`ifdef HP_STICKY_FLAGS_EN
        , .flag_clear(a_flag_clear), .sticky_flags(a_sticky)
`endif
    );

    hp_fpu_req_ctrl #(.num_bits(16), .tag_width(3), .resp_depth(2), .fpu_latency(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_src_a(b_req_src_a), .req_src_b(b_req_src_b), .req_op(b_req_op), .req_tag(b_req_tag),
        .fpu_src_a(b_fpu_src_a), .fpu_src_b(b_fpu_src_b), .fpu_operation(b_fpu_op),
        .fpu_res(b_fpu_res), .fpu_flags(b_fpu_flags),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_result(b_resp_result), .resp_flags(b_resp_flags), .resp_tag(b_resp_tag),
        .busy(b_busy)
`ifdef HP_STICKY_FLAGS_EN
        , .flag_clear(b_flag_clear), .sticky_flags(b_sticky)
`endif
    );

    // Record handshakes seen at the coming edge, then advance one cycle.
    // Called once inputs have settled (posedge + 2).
    task automatic step();
        rsp_t e;
        if (!reset) begin
            if (a_req_valid && a_req_ready) begin
                e.res = fpu_res_f(a_req_src_a, a_req_src_b, a_req_op);
                e.fl  = fpu_flags_f(a_req_src_a, a_req_src_b, a_req_op);
                e.tag = a_req_tag;
                a_exp.push_back(e);
            end
            if (a_resp_valid && a_resp_ready) begin
                e.res = a_resp_result; e.fl = a_resp_flags; e.tag = a_resp_tag;
                a_obs.push_back(e);
            end
            if (b_req_valid && b_req_ready) begin
                e.res = fpu_res_f(b_req_src_a, b_req_src_b, b_req_op);
                e.fl  = fpu_flags_f(b_req_src_a, b_req_src_b, b_req_op);
                e.tag = b_req_tag;
                b_exp.push_back(e);
            end
            if (b_resp_valid && b_resp_ready) begin
                e.res = b_resp_result; e.fl = b_resp_flags; e.tag = b_resp_tag;
                b_obs.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        #1;
        n_checks++;
        if (a_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_low: got %b expected 0", a_req_ready);
        end
        step(); #1; step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (a_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", a_resp_valid);
        end
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy);
        end
        n_checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b/%b expected 1/1", a_req_ready, b_req_ready);
        end
        n_checks++;
        if (a_fpu_src_a !== 16'h0 || a_resp_result !== 16'h0 || a_fpu_op !== 3'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%h/%h expected 0", a_fpu_src_a, a_resp_result, a_fpu_op);
        end
`ifdef HP_STICKY_FLAGS_EN
        n_checks++;
        if (a_sticky !== 6'b0) begin
            n_fail++; $display("FAIL reset_sticky: got %b expected 0", a_sticky);
        end
`endif
        step();
    endtask

    task automatic directed_op(input string name, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [2:0] tag,
                               input logic [15:0] exp_res, input logic [5:0] exp_fl);
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_op = op; a_req_src_a = a; a_req_src_b = b; a_req_tag = tag;
        #1;
        n_checks++;
        if (a_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_accept: req_ready got %b expected 1", name, a_req_ready);
        end
        step();
        a_req_valid = 1'b0;
        #1;
        n_checks++;
        if (a_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_early: resp_valid got %b expected 0 one cycle after accept", name, a_resp_valid);
        end
        step();
        #1;
        n_checks++;
        if (a_resp_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_latency: resp_valid got %b expected 1 two cycles after accept", name, a_resp_valid);
        end
        n_checks++;
        if (a_resp_result !== exp_res || a_resp_flags !== exp_fl || a_resp_tag !== tag) begin
            n_fail++;
            $display("FAIL %s_resp: got %h/%b/%0d expected %h/%b/%0d", name,
                     a_resp_result, a_resp_flags, a_resp_tag, exp_res, exp_fl, tag);
        end
        a_resp_ready = 1'b1;
        step();
        a_resp_ready = 1'b0;
        a_exp.delete(); a_obs.delete();
    endtask

    task automatic test_add();
        directed_op("add", c_ADD_RN, 16'h3C00, 16'h4000, 3'd5, 16'h4200, 6'b000100);
    endtask

    task automatic test_mul();
        directed_op("mul", c_MUL_RN, 16'h7BFF, 16'h4000, 3'd6, 16'h7C00, 6'b010000);
    endtask

    task automatic test_backpressure();
        int sent = 0;
        a_resp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            a_req_valid = (sent < 3); a_req_tag = 3'(sent + 1);
            a_req_src_a = 16'($urandom); a_req_src_b = 16'($urandom); a_req_op = 3'($urandom);
            #1;
            if (c >= 2) begin
                n_checks++;
                if (a_req_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_ready_held: cycle %0d req_ready got %b expected 0", c, a_req_ready);
                end
            end
            if (a_req_valid && a_req_ready) sent++;
            step();
        end
        n_checks++;
        if (sent != 2) begin
            n_fail++; $display("FAIL bp_accepted: got %0d expected 2 while queue full", sent);
        end
        a_resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a_req_valid = (sent < 3); a_req_tag = 3'(sent + 1);
            #1;
            if (a_req_valid && a_req_ready) sent++;
            step();
        end
        a_req_valid = 1'b0;
        n_checks++;
        if (a_obs.size() != 3) begin
            n_fail++; $display("FAIL bp_count: got %0d responses expected 3", a_obs.size());
        end
        for (int i = 0; i < 3 && i < a_obs.size() && i < a_exp.size(); i++) begin
            n_checks++;
            if (a_obs[i].tag !== 3'(i + 1) || a_obs[i] !== a_exp[i]) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h tag %0d", i, a_obs[i], a_exp[i], i + 1);
            end
        end
        a_resp_ready = 1'b0;
        a_exp.delete(); a_obs.delete();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            a_req_valid  = ($urandom_range(0, 9) < 7);
            a_req_src_a  = 16'($urandom); a_req_src_b = 16'($urandom);
            a_req_op     = 3'($urandom); a_req_tag = 3'($urandom);
            a_resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (a_busy !== (a_exp.size() > a_obs.size())) begin
                n_fail++; $display("FAIL rand_busy: cycle %0d got %b with %0d outstanding", c, a_busy, a_exp.size() - a_obs.size());
            end
            step();
        end
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1; step();
        end
        n_checks++;
        if (a_obs.size() != a_exp.size() || a_exp.size() < 50) begin
            n_fail++; $display("FAIL rand_count: got %0d responses expected %0d", a_obs.size(), a_exp.size());
        end
        for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
            n_checks++;
            if (a_obs[i] !== a_exp[i]) begin
                n_fail++; $display("FAIL rand_resp[%0d]: got %h expected %h", i, a_obs[i], a_exp[i]);
            end
        end
        a_resp_ready = 1'b0;
        a_exp.delete(); a_obs.delete();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_src_a = 16'h1234; a_req_src_b = 16'h5678; a_req_op = c_SUB_RN; a_req_tag = 3'd1;
        #1; step();
        a_req_tag = 3'd2;
        #1; step();
        a_req_valid = 1'b0;
        #1;
        n_checks++;
        if (a_resp_valid !== 1'b1 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: resp_valid/busy got %b/%b expected 1/1", a_resp_valid, a_busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (a_resp_valid !== 1'b0 || a_busy !== 1'b0 || a_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_post: resp_valid/busy/req_ready got %b/%b/%b expected 0/0/1", a_resp_valid, a_busy, a_req_ready);
        end
        a_resp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (a_resp_valid !== 1'b0) stray++;
            step();
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL rstmid_stray: got %0d cycles with resp_valid expected 0", stray);
        end
        a_resp_ready = 1'b0;
        a_exp.delete(); a_obs.delete();
    endtask

`ifdef HP_STICKY_FLAGS_EN
    task automatic test_sticky();
        a_resp_ready = 1'b1; a_flag_clear = 1'b0;
        a_req_valid = 1'b1; a_req_op = c_MUL_RN; a_req_src_a = 16'h7BFF; a_req_src_b = 16'h4000; a_req_tag = 3'd3;
        #1; step();
        a_req_valid = 1'b0;
        #1; step();
        #1;
        n_checks++;
        if (a_sticky !== 6'b010000) begin
            n_fail++; $display("FAIL sticky_inf: got %b expected 010000", a_sticky);
        end
        a_req_valid = 1'b1; a_req_op = c_ADD_RN; a_req_src_a = 16'h3C00; a_req_src_b = 16'h4000; a_req_tag = 3'd4;
        #1; step();
        a_req_valid = 1'b0; a_flag_clear = 1'b1;
        #1; step();
        a_flag_clear = 1'b0;
        #1;
        n_checks++;
        if (a_sticky !== 6'b000100) begin
            n_fail++; $display("FAIL sticky_clear_push: got %b expected 000100", a_sticky);
        end
        a_flag_clear = 1'b1;
        step();
        a_flag_clear = 1'b0;
        #1;
        n_checks++;
        if (a_sticky !== 6'b000000) begin
            n_fail++; $display("FAIL sticky_clear: got %b expected 000000", a_sticky);
        end
        step();
        a_resp_ready = 1'b0;
        a_exp.delete(); a_obs.delete();
    endtask
`endif

    task automatic test_latency3();
        int          n_acc = 0, last = 0, first = -1, first_resp = -1, hold_left = 0;
        logic [15:0] hold_a = '0, hold_b = '0;
        b_resp_ready = 1'b1;
        b_req_valid  = 1'b1;
        for (int c = 0; c < 45; c++) begin
            b_req_src_a = 16'($urandom); b_req_src_b = 16'($urandom);
            b_req_op = 3'($urandom); b_req_tag = 3'($urandom);
            #1;
            if (hold_left > 0) begin
                n_checks++;
                if (b_fpu_src_a !== hold_a || b_fpu_src_b !== hold_b) begin
                    n_fail++; $display("FAIL lat3_hold: got %h/%h expected %h/%h", b_fpu_src_a, b_fpu_src_b, hold_a, hold_b);
                end
                hold_left--;
            end
            if (b_resp_valid && first_resp < 0) first_resp = cyc;
            if (b_req_ready) begin
                if (n_acc > 0) begin
                    n_checks++;
                    if (cyc - last != 3) begin
                        n_fail++; $display("FAIL lat3_spacing: got %0d cycles expected 3", cyc - last);
                    end
                end else begin
                    first = cyc;
                end
                last = cyc; n_acc++;
                hold_a = b_req_src_a; hold_b = b_req_src_b; hold_left = 3;
            end
            step();
        end
        b_req_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1; step();
        end
        n_checks++;
        if (first < 0 || first_resp - first != 4) begin
            n_fail++; $display("FAIL lat3_latency: got %0d cycles expected 4", first_resp - first);
        end
        n_checks++;
        if (n_acc < 14 || b_obs.size() != b_exp.size()) begin
            n_fail++; $display("FAIL lat3_count: accepted %0d responses %0d expected >=14 and %0d", n_acc, b_obs.size(), b_exp.size());
        end
        for (int i = 0; i < b_obs.size() && i < b_exp.size(); i++) begin
            n_checks++;
            if (b_obs[i] !== b_exp[i]) begin
                n_fail++; $display("FAIL lat3_resp[%0d]: got %h expected %h", i, b_obs[i], b_exp[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a_req_valid = 1'b0; a_resp_ready = 1'b0; a_req_src_a = '0; a_req_src_b = '0; a_req_op = '0; a_req_tag = '0;
        b_req_valid = 1'b0; b_resp_ready = 1'b0; b_req_src_a = '0; b_req_src_b = '0; b_req_op = '0; b_req_tag = '0;
`ifdef HP_STICKY_FLAGS_EN
        a_flag_clear = 1'b0; b_flag_clear = 1'b0;
`endif
        test_reset();
        test_add();
        test_mul();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef HP_STICKY_FLAGS_EN
        test_sticky();
`endif
        test_latency3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
